// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide.
// Ports: clk, reset, start, funct3, op_a, op_b, rd_in -> busy, done, result, wb_rd, wb_en.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      wb_rd,
    output logic            wb_en
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX,
        DONE
    } state_t;

    state_t      state;
    logic [4:0]  cnt;
    logic [2:0]  fn;
    logic [4:0]  rd_q;
    logic        neg_res;
    logic        neg_rem;
    // hi: product high half / partial remainder
    // lo: multiplier / dividend shifting into quotient
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] bq;

    logic        is_div;
    logic        sa_en;
    logic        sb_en;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_zero;
    logic        div_ovf;
    logic        fast;
    logic [31:0] fast_res;

    logic [32:0] sum;
    logic [32:0] r;
    logic        ge;
    logic [31:0] diff;
    logic [31:0] hi_n;
    logic [31:0] lo_n;

    logic [63:0] prod;
    logic [63:0] prod_s;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] fix_res;

    // Operand preparation for an accepted start
    always_comb begin
        is_div   = funct3[2];
        sa_en    = (funct3 == 3'b001) || (funct3 == 3'b010)
                 || (is_div && !funct3[0]);
        sb_en    = (funct3 == 3'b001) || (is_div && !funct3[0]);
        sign_a   = sa_en && op_a[31];
        sign_b   = sb_en && op_b[31];
        mag_a    = sign_a ? (32'd0 - op_a) : op_a;
        mag_b    = sign_b ? (32'd0 - op_b) : op_b;
        div_zero = is_div && (op_b == 32'd0);
        div_ovf  = is_div && !funct3[0]
                 && (op_a == 32'h8000_0000)
                 && (op_b == 32'hFFFF_FFFF);
        fast     = div_zero || div_ovf;
        fast_res = 32'd0;
        if (div_zero) begin
            fast_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            fast_res = funct3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // One iteration of the shared datapath
    always_comb begin
        sum  = {1'b0, hi} + {1'b0, (lo[0] ? bq : 32'd0)};
        r    = {hi, lo[31]};
        ge   = (r >= {1'b0, bq});
        diff = r[31:0] - bq;
        if (fn[2]) begin
            hi_n = ge ? diff : r[31:0];
            lo_n = {lo[30:0], ge};
        end else begin
            hi_n = sum[32:1];
            lo_n = {sum[0], lo[31:1]};
        end
    end

    // Sign correction and result select
    always_comb begin
        prod    = {hi, lo};
        prod_s  = neg_res ? (64'd0 - prod) : prod;
        quo     = neg_res ? (32'd0 - lo) : lo;
        rem     = neg_rem ? (32'd0 - hi) : hi;
        if (fn[2]) begin
            fix_res = fn[1] ? rem : quo;
        end else begin
            fix_res = (fn == 3'b000) ? prod_s[31:0] : prod_s[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 5'd0;
            fn      <= 3'd0;
            rd_q    <= 5'd0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            bq      <= 32'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= 32'd0;
            wb_rd   <= 5'd0;
            wb_en   <= 1'b0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    wb_en <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        fn   <= funct3;
                        rd_q <= rd_in;
                        if (fast) begin
                            result <= fast_res;
                            wb_rd  <= rd_in;
                            wb_en  <= (rd_in != 5'd0);
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            hi      <= 32'd0;
                            lo      <= mag_a;
                            bq      <= mag_b;
                            neg_res <= sign_a ^ sign_b;
                            neg_rem <= sign_a;
                            cnt     <= 5'd0;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end
                    end
                end
                RUN: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= fix_res;
                    wb_rd  <= rd_q;
                    wb_en  <= (rd_q != 5'd0);
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed testbench for muldiv_unit.
// Ports driven: clk, reset, start, funct3, op_a, op_b, rd_in; all outputs observed.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  wb_rd;
    logic        wb_en;

    int n_checks;
    int n_fail;

    muldiv_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wb_rd  (wb_rd),
        .wb_en  (wb_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start is held through one edge (the cycle-0 edge); returns in cycle 1.
    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
        funct3 = f;
        op_a   = a;
        op_b   = b;
        rd_in  = rd;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    // Counts cycles from cyc0 until done; bounded.
    task automatic wait_done(input int cyc0, output int cyc, output int nbusy);
        cyc   = cyc0;
        nbusy = 0;
        while (!done && cyc < cyc0 + 100) begin
            if (busy) nbusy++;
            step();
            cyc++;
        end
        if (!done) cyc = -1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        funct3 = 3'd0;
        op_a = 32'd0;
        op_b = 32'd0;
        rd_in = 5'd0;
        step();
        step();
        reset = 1'b0;
        n_checks++;
        if ({busy, done, wb_en} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000", {busy, done, wb_en});
        end
        n_checks++;
        if (result !== 32'd0 || wb_rd !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_data: got %h/%0d want 0/0", result, wb_rd);
        end
    endtask

    task automatic test_mul();
        int cyc, nb;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        wait_done(1, cyc, nb);
        n_checks++;
        if (cyc !== 34 || nb !== 33) begin
            n_fail++;
            $display("FAIL mul_timing: got done@%0d busy=%0d want 34/33", cyc, nb);
        end
        n_checks++;
        if (result !== 32'hFFFF_FFEB) begin
            n_fail++;
            $display("FAIL mul_result: got %h want ffffffeb", result);
        end
        n_checks++;
        if (wb_rd !== 5'd5 || wb_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mul_wb: got rd=%0d en=%b want 5/1", wb_rd, wb_en);
        end
        step();
        n_checks++;
        if (done !== 1'b0 || wb_en !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_pulse: got done=%b en=%b want 0/0", done, wb_en);
        end
    endtask

    task automatic test_mulh();
        logic [2:0]  fv [3] = '{3'b011, 3'b001, 3'b010};
        logic [31:0] ev [3] = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF};
        int cyc, nb;
        for (int i = 0; i < 3; i++) begin
            issue(fv[i], 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
            wait_done(1, cyc, nb);
            n_checks++;
            if (cyc !== 34 || result !== ev[i]) begin
                n_fail++;
                $display("FAIL mulh_f%0d: got %h@%0d want %h@34",
                         fv[i], result, cyc, ev[i]);
            end
            step();
        end
    endtask

    task automatic test_div();
        logic [2:0]  fv [3] = '{3'b100, 3'b110, 3'b101};
        logic [31:0] ev [3] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
        int cyc, nb;
        for (int i = 0; i < 3; i++) begin
            issue(fv[i], 32'hFFFF_FFF9, 32'd2, 5'd7);
            wait_done(1, cyc, nb);
            n_checks++;
            if (cyc !== 34 || nb !== 33 || result !== ev[i]) begin
                n_fail++;
                $display("FAIL div_f%0d: got %h@%0d busy=%0d want %h@34/33",
                         fv[i], result, cyc, nb, ev[i]);
            end
            step();
        end
    endtask

    task automatic test_fast();
        logic [2:0]  fv [4] = '{3'b101, 3'b111, 3'b100, 3'b110};
        logic [31:0] av [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bv [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] ev [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        int cyc, nb;
        for (int i = 0; i < 4; i++) begin
            issue(fv[i], av[i], bv[i], 5'd9);
            wait_done(1, cyc, nb);
            n_checks++;
            if (cyc !== 1 || nb !== 0 || busy !== 1'b0 || result !== ev[i]) begin
                n_fail++;
                $display("FAIL fast_%0d: got %h@%0d busy=%0d want %h@1/0",
                         i, result, cyc, nb, ev[i]);
            end
            step();
        end
    endtask

    task automatic test_ignore_start();
        int cyc, nb;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        for (int c = 1; c < 10; c++) step();
        funct3 = 3'b000;
        op_a   = 32'd3;
        op_b   = 32'd4;
        rd_in  = 5'd9;
        start  = 1'b1;
        step();
        start  = 1'b0;
        wait_done(11, cyc, nb);
        n_checks++;
        if (cyc !== 34 || result !== 32'hFFFF_FFEB || wb_rd !== 5'd5) begin
            n_fail++;
            $display("FAIL ignore_start: got %h rd=%0d @%0d want ffffffeb rd=5 @34",
                     result, wb_rd, cyc);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int seen;
        issue(3'b011, 32'd100, 32'd200, 5'd4);
        for (int c = 1; c < 20; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_mid: got busy=%b done=%b res=%h want 0/0/0",
                     busy, done, result);
        end
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            if (done || wb_en || busy) seen++;
            step();
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: got %0d active cycles want 0", seen);
        end
    endtask

    task automatic test_rd_zero();
        int cyc, nb;
        issue(3'b000, 32'd3, 32'd4, 5'd0);
        wait_done(1, cyc, nb);
        n_checks++;
        if (cyc !== 34 || wb_en !== 1'b0 || result !== 32'd12) begin
            n_fail++;
            $display("FAIL rd_zero: got en=%b res=%h @%0d want 0/c @34",
                     wb_en, result, cyc);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int cyc, nb;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
        wait_done(1, cyc, nb);
        n_checks++;
        if (cyc !== 34) begin
            n_fail++;
            $display("FAIL b2b_first: got done@%0d want 34", cyc);
        end
        issue(3'b000, 32'd3, 32'd4, 5'd6);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_drop: got done=%b busy=%b want 0/1", done, busy);
        end
        wait_done(35, cyc, nb);
        n_checks++;
        if (cyc !== 68 || nb !== 33 || result !== 32'd12 || wb_rd !== 5'd6) begin
            n_fail++;
            $display("FAIL b2b_second: got %h rd=%0d @%0d busy=%0d want c rd=6 @68/33",
                     result, wb_rd, cyc, nb);
        end
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_mul();
        test_mulh();
        test_div();
        test_fast();
        test_ignore_start();
        test_reset_mid();
        test_rd_zero();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit sitting between the register file read ports and its write port. It takes the two source operands read for an M-extension instruction and computes the result over multiple cycles. It then presents `rd`/`wdata`/`wen` for write-back, so the pipeline stalls on `busy` while it runs. One shared 32-iteration datapath serves both functions: shift-add for multiplies, restoring division for divides.

## Interface
- `XLEN`, 32, operand/result width; only 32 is supported.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE or DONE.
- `funct3`  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a`  input  32  rs1 value (register file `rdata1`); captured on accepted start.
- `op_b`  input  32  rs2 value (register file `rdata2`); captured on accepted start.
- `rd_in`  input  5  destination register; captured on accepted start.
- `busy`  output  1  high while an operation is in flight (RUN, FIX).
- `done`  output  1  one-cycle pulse, result valid.
- `result`  output  32  result; holds its value until the next completion.
- `wb_rd`  output  5  captured destination; feeds register file `rd`.
- `wb_en`  output  1  `done && wb_rd != 0`; feeds register file `wen`.

## Operation
- States:
  - IDLE: waiting.
  - RUN: 32 iterations, driven by a 5-bit counter.
  - FIX: sign correction and result select.
  - DONE: result presented.
- Transitions:
  - IDLE/DONE + `start` → RUN.
  - IDLE/DONE + `start` + special divide case → DONE directly (fast path).
  - DONE without `start` → IDLE.
  - RUN after counter reaches 31 → FIX.
  - FIX → DONE.
- Operand prep on accept:
  - Signedness of `op_a`: signed for MULH, MULHSU, DIV, REM.
  - Signedness of `op_b`: signed for MULH, DIV, REM.
  - MUL and MULHSU's `op_b` use unsigned/low-half semantics.
  - Magnitudes are stored; `neg_res` is recorded.
- Sign of the result:
  - Multiply: `neg_res` = sign_a XOR sign_b.
  - Quotient: sign_a XOR sign_b.
  - Remainder: takes the sign of the dividend (sign_a).
- Multiply: 64-bit product accumulator, one add-and-shift per RUN cycle.
  - FIX negates the 64-bit product (two's complement) if needed.
  - MUL selects the low 32 bits; MULH/MULHSU/MULHU select the high 32 bits.
- Divide: 33-bit partial remainder with restoring subtract per RUN cycle; FIX applies the sign corrections above.
- Fast path, no iterations:
  - Divide by zero (`op_b` == 0): DIV/DIVU return 0xFFFFFFFF; REM/REMU return `op_a`.
  - Signed overflow (DIV/REM with `op_a` = 0x80000000, `op_b` = 0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- `start` in RUN/FIX is ignored (no queueing); upstream must hold the instruction until it is accepted.
- `rd_in` = 0: the op executes and `done` pulses, but `wb_en` stays 0.

## Timing
- Start sampled high at cycle 0 edge (state IDLE/DONE), normal path:
  - `busy` is 1 in cycles 1–33: RUN in cycles 1–32, FIX in cycle 33.
  - `done`, `wb_en`, `result` and `wb_rd` are valid in cycle 34.
- Fast path: `done` in cycle 1, `busy` never asserted.
- Back-to-back: `start` in the DONE cycle is accepted. The next op's RUN begins in the following cycle; `done` drops there.
- Register file writes on the falling clock edge. `wb_rd`/`wb_en`/`result` are registered, stable for the whole DONE cycle, and committed mid-cycle.
- Reset, including mid-operation: next state is IDLE with `busy`=0, `done`=0, `wb_en`=0, `result`=0, `wb_rd`=0, counter=0. The in-flight op is discarded and no write-back occurs.
- Reset has priority over a simultaneous `start`.

## Test plan
- MUL: `op_a`=7, `op_b`=0xFFFFFFFD (-3), `rd_in`=5, start at cycle 0 → `busy` high cycles 1–33; cycle 34: `done`=1, `result`=0xFFFFFFEB, `wb_rd`=5, `wb_en`=1.
- High multiplies with `op_a`=`op_b`=0xFFFFFFFF:
  - MULHU → 0xFFFFFFFE.
  - MULH → 0x00000000.
  - MULHSU → 0xFFFFFFFF.
  - Each completes at cycle 34.
- Signed divide with `op_a`=0xFFFFFFF9 (-7), `op_b`=2:
  - DIV → 0xFFFFFFFD.
  - REM → 0xFFFFFFFF.
  - DIVU with the same operands → 0x7FFFFFFC.
- Special cases, each with `done` in cycle 1 and `busy` never high:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Control corner cases:
  - Second `start` pulsed in cycle 10 → ignored; the first result is unchanged at cycle 34.
  - `reset` in cycle 20 → cycle 21: `busy`=0 and no `done`/`wb_en` ever appears.
  - `rd_in`=0 → `done`=1 with `wb_en`=0.
- Back-to-back: second MUL (3×4) started in DONE cycle 34 → `done` at cycle 68 with `result`=12. `done` is low in cycles 35–67.
